// File: rtl/integer_writeback.sv
// integer_writeback: buffers integer execute results (dst, npc, mispredict)
// in a small in-order FIFO and drains them into the ROB writeback port.
// ex_ready depends only on registered occupancy; a flush empties the buffer.
// A saturating counter tracks mispredicted branch/jalr writebacks.
// Optional build macro INTEGER_WB_BYPASS_EN: when the buffer is empty, a new
// execute result is shown to the ROB in the same cycle and retires without
// being stored if the ROB accepts it.
module integer_writeback #(
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 5,
    parameter int DEPTH        = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_aH,
    input  logic                    ex_valid,
    input  logic [ROB_ID_WIDTH-1:0] ex_rob_id,
    input  logic                    ex_dst_valid,
    input  logic [WORD_WIDTH-1:0]   ex_dst,
    input  logic                    ex_npc_wb_valid,
    input  logic                    ex_npc_mispred,
    input  logic [ADDR_WIDTH-1:0]   ex_npc,
    output logic                    ex_ready,
    input  logic                    flush,
    output logic                    rob_wb_valid,
    input  logic                    rob_wb_ready,
    output logic [ROB_ID_WIDTH-1:0] rob_wb_rob_id,
    output logic                    rob_wb_dst_valid,
    output logic [WORD_WIDTH-1:0]   rob_wb_dst,
    output logic                    rob_wb_npc_valid,
    output logic [ADDR_WIDTH-1:0]   rob_wb_npc,
    output logic                    rob_wb_mispred,
    output logic [CNT_WIDTH-1:0]    mispred_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [ROB_ID_WIDTH-1:0] mem_rob_id    [DEPTH];
    logic                    mem_dst_valid [DEPTH];
    logic [WORD_WIDTH-1:0]   mem_dst       [DEPTH];
    logic                    mem_npc_valid [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_npc       [DEPTH];
    logic                    mem_mispred   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;

    logic                  empty;
    logic                  full;
    logic                  byp_active;
    logic                  push;
    logic                  pop_buf;
    logic                  retire_mispred;
    logic                  in_mispred;
    logic [WORD_WIDTH-1:0] in_dst;
    logic [ADDR_WIDTH-1:0] in_npc;

    assign empty    = (count == '0);
    assign full     = (count == OCC_FULL);
    assign ex_ready = ~full;

    // Masking is applied on entry so the stored payload is already clean.
    assign in_mispred = ex_npc_mispred & ex_npc_wb_valid;
    assign in_npc     = ex_npc_wb_valid ? ex_npc : '0;
    assign in_dst     = ex_dst_valid ? ex_dst : '0;

`ifdef INTEGER_WB_BYPASS_EN
    assign byp_active = empty & ex_valid & ~flush;
`else
    assign byp_active = 1'b0;
`endif

    // A bypassed result that the ROB takes this cycle never occupies a slot.
    assign push    = ex_valid & ~full & ~flush & ~(byp_active & rob_wb_ready);
    assign pop_buf = ~empty & rob_wb_ready;

    // Counts every retirement, buffered or bypassed, including one that
    // coincides with a flush.
    assign retire_mispred = rob_wb_valid & rob_wb_ready & rob_wb_mispred;

    // Present the head entry (or the bypassed input); zero payload when idle.
    always_comb begin
        rob_wb_valid     = 1'b0;
        rob_wb_rob_id    = '0;
        rob_wb_dst_valid = 1'b0;
        rob_wb_dst       = '0;
        rob_wb_npc_valid = 1'b0;
        rob_wb_npc       = '0;
        rob_wb_mispred   = 1'b0;
        if (!empty) begin
            rob_wb_valid     = 1'b1;
            rob_wb_rob_id    = mem_rob_id[head];
            rob_wb_dst_valid = mem_dst_valid[head];
            rob_wb_dst       = mem_dst[head];
            rob_wb_npc_valid = mem_npc_valid[head];
            rob_wb_npc       = mem_npc[head];
            rob_wb_mispred   = mem_mispred[head];
        end else if (byp_active) begin
            rob_wb_valid     = 1'b1;
            rob_wb_rob_id    = ex_rob_id;
            rob_wb_dst_valid = ex_dst_valid;
            rob_wb_dst       = in_dst;
            rob_wb_npc_valid = ex_npc_wb_valid;
            rob_wb_npc       = in_npc;
            rob_wb_mispred   = in_mispred;
        end
    end

    // Pointer and occupancy tracking; flush wins over any push.
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_buf) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop_buf})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rob_id[tail]    <= ex_rob_id;
            mem_dst_valid[tail] <= ex_dst_valid;
            mem_dst[tail]       <= in_dst;
            mem_npc_valid[tail] <= ex_npc_wb_valid;
            mem_npc[tail]       <= in_npc;
            mem_mispred[tail]   <= in_mispred;
        end
    end

    // Saturating mispredict counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            mispred_cnt <= '0;
        end else if (retire_mispred && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_integer_writeback.sv
// Randomized and directed bench for integer_writeback using a queue-based
// reference model of the writeback buffer and mispredict counter.
module tb_integer_writeback;

    localparam int W = 32;
    localparam int A = 32;
    localparam int R = 5;
    localparam int D = 2;
    localparam int C = 16;

    typedef struct packed {
        logic [R-1:0] id;
        logic         dv;
        logic [W-1:0] dst;
        logic         nv;
        logic [A-1:0] npc;
        logic         mp;
    } ent_t;

    localparam int BUS_W = 1 + $bits(ent_t);

    logic         clk = 1'b0;
    logic         rst_aH = 1'b1;
    logic         ex_valid = 1'b0;
    logic [R-1:0] ex_rob_id = '0;
    logic         ex_dst_valid = 1'b0;
    logic [W-1:0] ex_dst = '0;
    logic         ex_npc_wb_valid = 1'b0;
    logic         ex_npc_mispred = 1'b0;
    logic [A-1:0] ex_npc = '0;
    logic         ex_ready;
    logic         flush = 1'b0;
    logic         rob_wb_valid;
    logic         rob_wb_ready = 1'b0;
    logic [R-1:0] rob_wb_rob_id;
    logic         rob_wb_dst_valid;
    logic [W-1:0] rob_wb_dst;
    logic         rob_wb_npc_valid;
    logic [A-1:0] rob_wb_npc;
    logic         rob_wb_mispred;
    logic [C-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    ent_t         q[$];
    logic [C-1:0] m_cnt = '0;

    logic [BUS_W-1:0] act_bus;
    assign act_bus = {rob_wb_valid, rob_wb_rob_id, rob_wb_dst_valid, rob_wb_dst,
                      rob_wb_npc_valid, rob_wb_npc, rob_wb_mispred};

    integer_writeback #(
        .WORD_WIDTH(W), .ADDR_WIDTH(A), .ROB_ID_WIDTH(R), .DEPTH(D), .CNT_WIDTH(C)
    ) dut (
        .clk(clk), .rst_aH(rst_aH),
        .ex_valid(ex_valid), .ex_rob_id(ex_rob_id), .ex_dst_valid(ex_dst_valid),
        .ex_dst(ex_dst), .ex_npc_wb_valid(ex_npc_wb_valid),
        .ex_npc_mispred(ex_npc_mispred), .ex_npc(ex_npc), .ex_ready(ex_ready),
        .flush(flush), .rob_wb_valid(rob_wb_valid), .rob_wb_ready(rob_wb_ready),
        .rob_wb_rob_id(rob_wb_rob_id), .rob_wb_dst_valid(rob_wb_dst_valid),
        .rob_wb_dst(rob_wb_dst), .rob_wb_npc_valid(rob_wb_npc_valid),
        .rob_wb_npc(rob_wb_npc), .rob_wb_mispred(rob_wb_mispred),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t mask_in();
        ent_t e;
        e.id  = ex_rob_id;
        e.dv  = ex_dst_valid;
        e.dst = ex_dst_valid ? ex_dst : '0;
        e.nv  = ex_npc_wb_valid;
        e.npc = ex_npc_wb_valid ? ex_npc : '0;
        e.mp  = ex_npc_mispred & ex_npc_wb_valid;
        return e;
    endfunction

    function automatic logic [BUS_W-1:0] exp_bus();
        ent_t e = '0;
        logic v = 1'b0;
        if (q.size() != 0) begin
            e = q[0];
            v = 1'b1;
        end
`ifdef INTEGER_WB_BYPASS_EN
        else if (ex_valid && !flush) begin
            e = mask_in();
            v = 1'b1;
        end
`endif
        return {v, e};
    endfunction

    function automatic logic exp_ready();
        return q.size() != D;
    endfunction

    task automatic model_edge();
        ent_t e = mask_in();
        bit   byp = 1'b0;
        bit   push;
        bit   pop;
`ifdef INTEGER_WB_BYPASS_EN
        byp = (q.size() == 0) && ex_valid && !flush;
`endif
        push = ex_valid && (q.size() != D) && !flush && !(byp && rob_wb_ready);
        pop  = (q.size() != 0) && rob_wb_ready;
        if (pop) begin
            if (q[0].mp && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            void'(q.pop_front());
        end else if (byp && rob_wb_ready && e.mp && m_cnt != '1) begin
            m_cnt = m_cnt + 1'b1;
        end
        if (flush) q.delete();
        else if (push) q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [R-1:0] id, input logic dv,
                         input logic [W-1:0] d, input logic nv, input logic mp,
                         input logic [A-1:0] pc, input logic fl, input logic rdy);
        ex_valid        = v;
        ex_rob_id       = id;
        ex_dst_valid    = dv;
        ex_dst          = d;
        ex_npc_wb_valid = nv;
        ex_npc_mispred  = mp;
        ex_npc          = pc;
        flush           = fl;
        rob_wb_ready    = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_aH = 1'b1;
        q.delete();
        m_cnt = '0;
        idle(1'b0);
        @(negedge clk);
        rst_aH = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (act_bus !== '0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0", act_bus);
        end
        checks++;
        if (ex_ready !== 1'b1 || mispred_cnt !== '0) begin
            errors++;
            $display("FAIL reset_ready_cnt got ready=%b cnt=%h want ready=1 cnt=0",
                     ex_ready, mispred_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        drive(1'b1, 5'd3, 1'b1, 32'h0000_00AA, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        checks++;
        if (rob_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency got valid=%b want 0", rob_wb_valid);
        end
        tick();
        idle(1'b1);
        checks++;
        if (rob_wb_valid !== 1'b1 || rob_wb_rob_id !== 5'd3 || rob_wb_dst !== 32'hAA ||
            rob_wb_npc_valid !== 1'b0 || rob_wb_npc !== '0) begin
            errors++;
            $display("FAIL single_head got v=%b id=%0d dst=%h nv=%b npc=%h want v=1 id=3 dst=aa nv=0 npc=0",
                     rob_wb_valid, rob_wb_rob_id, rob_wb_dst, rob_wb_npc_valid, rob_wb_npc);
        end
        checks++;
        if (act_bus !== exp_bus()) begin
            errors++;
            $display("FAIL single_model got %h want %h", act_bus, exp_bus());
        end
        tick();
        checks++;
        if (rob_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drained got valid=%b want 0", rob_wb_valid);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 5'd1, 1'b1, 32'h11, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", ex_ready);
        end
        drive(1'b1, 5'd4, 1'b1, 32'h44, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_bus !== exp_bus()) begin
                errors++;
                $display("FAIL full_drain%0d got %h want %h", i, act_bus, exp_bus());
            end
            checks++;
            if (i < 2 && rob_wb_rob_id !== R'(i + 1)) begin
                errors++;
                $display("FAIL full_order%0d got id=%0d want %0d", i, rob_wb_rob_id, i + 1);
            end else if (i == 2 && rob_wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_no_id4 got valid=%b id=%0d want valid=0", rob_wb_valid, rob_wb_rob_id);
            end
            tick();
        end
    endtask

    task automatic test_full_pushpop();
        drive(1'b1, 5'd8, 1'b0, 32'h5, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 32'h6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (ex_ready !== 1'b0 || rob_wb_dst !== '0 || rob_wb_rob_id !== 5'd8) begin
            errors++;
            $display("FAIL pp_full got ready=%b id=%0d dst=%h want ready=0 id=8 dst=0",
                     ex_ready, rob_wb_rob_id, rob_wb_dst);
        end
        tick();
        checks++;
        if (ex_ready !== 1'b1 || rob_wb_rob_id !== 5'd9) begin
            errors++;
            $display("FAIL pp_refused got ready=%b id=%0d want ready=1 id=9", ex_ready, rob_wb_rob_id);
        end
        drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        checks++;
        if (ex_ready !== 1'b0 || act_bus !== exp_bus()) begin
            errors++;
            $display("FAIL pp_accept got ready=%b bus=%h want ready=0 bus=%h", ex_ready, act_bus, exp_bus());
        end
        tick();
        checks++;
        if (rob_wb_rob_id !== 5'd5 || rob_wb_dst !== 32'h55) begin
            errors++;
            $display("FAIL pp_second got id=%0d dst=%h want id=5 dst=55", rob_wb_rob_id, rob_wb_dst);
        end
        tick();
    endtask

    task automatic test_mispred();
        logic [C-1:0] cnt0;
        cnt0 = m_cnt;
        drive(1'b1, 5'd10, 1'b0, 32'hDEAD, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd11, 1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h0000_2222, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        checks++;
        if (rob_wb_mispred !== 1'b1 || rob_wb_npc !== 32'h1000 || rob_wb_dst !== '0) begin
            errors++;
            $display("FAIL mp_branch got mp=%b npc=%h dst=%h want mp=1 npc=1000 dst=0",
                     rob_wb_mispred, rob_wb_npc, rob_wb_dst);
        end
        tick();
        checks++;
        if (rob_wb_mispred !== 1'b0 || rob_wb_npc !== '0 || rob_wb_dst !== 32'hBEEF) begin
            errors++;
            $display("FAIL mp_jal got mp=%b npc=%h dst=%h want mp=0 npc=0 dst=beef",
                     rob_wb_mispred, rob_wb_npc, rob_wb_dst);
        end
        tick();
        checks++;
        if (mispred_cnt !== cnt0 + 1'b1) begin
            errors++;
            $display("FAIL mp_count got %0d want %0d", mispred_cnt, cnt0 + 1'b1);
        end
    endtask

    task automatic test_flush();
        logic [C-1:0] cnt0;
        drive(1'b1, 5'd12, 1'b1, 32'h1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd13, 1'b1, 32'h2, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
        tick();
        cnt0 = m_cnt;
        drive(1'b1, 5'd14, 1'b1, 32'h3, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        checks++;
        if (rob_wb_valid !== 1'b0 || ex_ready !== 1'b1 || mispred_cnt !== cnt0) begin
            errors++;
            $display("FAIL flush_state got v=%b ready=%b cnt=%0d want v=0 ready=1 cnt=%0d",
                     rob_wb_valid, ex_ready, mispred_cnt, cnt0);
        end
        drive(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        checks++;
        if (rob_wb_valid !== 1'b1 || rob_wb_rob_id !== 5'd7) begin
            errors++;
            $display("FAIL flush_id7 got v=%b id=%0d want v=1 id=7", rob_wb_valid, rob_wb_rob_id);
        end
        tick();
        checks++;
        if (rob_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_alone got v=%b want 0", rob_wb_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), R'($urandom), 1'($urandom), $urandom,
                  1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0));
            checks++;
            if (act_bus !== exp_bus() || ex_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_out%0d got bus=%h ready=%b want bus=%h ready=%b",
                         i, act_bus, ex_ready, exp_bus(), exp_ready());
            end
            tick();
            checks++;
            if (mispred_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_cnt%0d got %0d want %0d", i, mispred_cnt, m_cnt);
            end
        end
        idle(1'b1);
        tick();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, R'(i), 1'b0, '0, 1'b1, 1'b1, A'(i), 1'b0, 1'b1);
            tick();
        end
        checks++;
        if (mispred_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_count got %h want ffff", mispred_cnt);
        end
        drive(1'b1, 5'd20, 1'b1, 32'h20, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd21, 1'b1, 32'h21, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        tick();
        checks++;
        if (rob_wb_valid !== 1'b1 || act_bus !== exp_bus()) begin
            errors++;
            $display("FAIL sat_middrain got %h want %h", act_bus, exp_bus());
        end
        #3;
        rst_aH = 1'b1;
        q.delete();
        m_cnt = '0;
        #1;
        checks++;
        if (rob_wb_valid !== 1'b0 || mispred_cnt !== '0 || ex_ready !== 1'b1 || act_bus !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b cnt=%h ready=%b want v=0 cnt=0 ready=1",
                     rob_wb_valid, mispred_cnt, ex_ready);
        end
        @(negedge clk);
        rst_aH = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_pushpop();
        test_mispred();
        test_flush();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/integer_writeback.md
Name: integer_writeback

Overview:
- Writeback stage directly downstream of the integer execute stage.
- Captures each completed integer result (dst, npc, mispredict flag) into a small in-order buffer, then drains it into the ROB writeback port under a valid/ready handshake.
- Backpressures integer issue through `ex_ready` and discards buffered results on a pipeline flush.
- Keeps a saturating count of branch/jalr mispredicts written back.

Parameters:
- WORD_WIDTH, 32, width of dst data.
- ADDR_WIDTH, 32, width of npc.
- ROB_ID_WIDTH, 5, width of ROB index.
- DEPTH, 2, buffer entries; power of two, >= 2.
- CNT_WIDTH, 16, mispredict counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_aH  in  1  asynchronous active-high reset.
- ex_valid  in  1  execute result valid this cycle.
- ex_rob_id  in  ROB_ID_WIDTH  ROB index of result.
- ex_dst_valid  in  1  instruction writes a destination register (not b_type).
- ex_dst  in  WORD_WIDTH  result data.
- ex_npc_wb_valid  in  1  b_type or jalr; npc must be written.
- ex_npc_mispred  in  1  direction/target mispredict.
- ex_npc  in  ADDR_WIDTH  resolved next pc.
- ex_ready  out  1  buffer can accept; issue stalls when 0.
- flush  in  1  ROB pipeline flush.
- rob_wb_valid  out  1  head entry presented to ROB.
- rob_wb_ready  in  1  ROB accepts head this cycle.
- rob_wb_rob_id  out  ROB_ID_WIDTH  head ROB index.
- rob_wb_dst_valid  out  1  head writes dst.
- rob_wb_dst  out  WORD_WIDTH  head dst data.
- rob_wb_npc_valid  out  1  head writes npc.
- rob_wb_npc  out  ADDR_WIDTH  head npc.
- rob_wb_mispred  out  1  head mispredicted.
- mispred_cnt  out  CNT_WIDTH  saturating mispredict writeback count.

Behaviour:
- **Reset** (async, rst_aH=1): head/tail pointers=0, count=0, all entries invalid, mispred_cnt=0, rob_wb_valid=0, all rob_wb_* payload=0, ex_ready=1. Release takes effect on the next clk edge.
- **Push**: `ex_valid & ex_ready & ~flush` writes an entry at tail; tail advances modulo DEPTH.
- **Pop**: `rob_wb_valid & rob_wb_ready` retires head; head advances modulo DEPTH.
- **Entry store masking**:
  - Stored mispred = `ex_npc_mispred & ex_npc_wb_valid`.
  - Stored npc = 0 when `ex_npc_wb_valid=0`.
  - Stored dst = 0 when `ex_dst_valid=0`.
- **ex_ready** = `(count != DEPTH)`. It is registered-state only, with no combinational path from rob_wb_ready.
- **Full**: ex_valid with ex_ready=0 is a protocol error. Upstream must hold issue, and the input is ignored.
- **Push and pop in the same cycle**:
  - Allowed whenever ex_ready=1; count is unchanged.
  - When full, push is refused even if a pop occurs.
- **Outputs**:
  - rob_wb_valid = `(count != 0)`.
  - rob_wb_* payload comes from the head entry, forced to 0 when empty.
  - Payload is held stable while `rob_wb_valid & ~rob_wb_ready`.
- **Latency**: minimum 1 cycle from ex_valid to rob_wb_valid.
- **Ordering**: strict FIFO; results reach the ROB in execute order.
- **Flush**:
  - Next edge sets count=0 and head=tail=0.
  - Any same-cycle push is dropped.
  - A same-cycle pop still counts toward mispred_cnt.
  - rob_wb_valid=0 the cycle after flush.
  - mispred_cnt is not cleared.
- **mispred_cnt**:
  - +1 on each pop whose entry has mispred=1.
  - Saturates at all ones.
  - Cleared only by reset.
- **Reset mid-operation**: all buffered entries are lost immediately (async); outputs go to reset values without waiting for clk.

Optional Feature:
- Macro INTEGER_WB_BYPASS_EN.
- **Defined**: when count==0, `ex_valid=1` and `flush=0`:
  - Execute inputs are presented combinationally on rob_wb_* with rob_wb_valid=1, applying the same masking.
  - If rob_wb_ready=1, the result retires without being written into the buffer (0-cycle latency); mispred_cnt counts it.
  - If rob_wb_ready=0, it is pushed normally.
- **Undefined**: strictly registered path; latency is always >= 1 cycle.

Test Plan:
- Reset, then rob_wb_ready=1; push rob_id=3, dst=0x0000_00AA, dst_valid=1 -> next cycle rob_wb_valid=1, rob_wb_rob_id=3, rob_wb_dst=0xAA, npc_valid=0, npc=0; the following cycle valid=0.
- Hold rob_wb_ready=0; push ids 1 and 2 -> ex_ready=0 after the 2nd push; 3rd ex_valid (id 4) ignored. Raise ready -> ids 1, 2 drain in order; id 4 never appears.
- Full buffer; rob_wb_ready=1 with ex_valid the same cycle -> push refused (ex_ready=0), pop occurs, count=1; the next cycle push accepted.
- Push branch with npc_wb_valid=1, mispred=1, npc=0x0000_1000, and jal with npc_wb_valid=0, mispred=1 -> first pop shows mispred=1, npc=0x1000; second shows mispred=0, npc=0; mispred_cnt=1.
- Buffer holding 2 entries; assert flush with ex_valid=1 -> next cycle rob_wb_valid=0, ex_ready=1, mispred_cnt unchanged; subsequent push id 7 appears alone.
- Preload mispred_cnt near saturation via 0xFFFF mispredict pops (CNT_WIDTH=16) -> stays 0xFFFF on the next mispredict pop. Assert rst_aH asynchronously mid-drain -> rob_wb_valid drops before the next clk edge and mispred_cnt=0.
